// File: rtl/bcd_pkg.sv
// Shared BCD constants, FSM state type and sizing helper for the BCD <-> binary converters.
// The binary-to-BCD block uses the DABBLE_* constants; bcd_to_bin uses the ADJ_* constants.
package bcd_pkg;

    localparam int DIGIT_W = 4;

    localparam logic [DIGIT_W-1:0] DIGIT_MAX     = 4'd9;
    localparam logic [DIGIT_W-1:0] ADJ_THRESH    = 4'd8;
    localparam logic [DIGIT_W-1:0] ADJ_VAL       = 4'd3;
    localparam logic [DIGIT_W-1:0] DABBLE_THRESH = 4'd5;
    localparam logic [DIGIT_W-1:0] DABBLE_VAL    = 4'd3;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CONV = 2'd1,
        DONE = 2'd2
    } state_t;

    // Smallest binary width that can hold 10^digits - 1.
    function automatic int min_bin_w(input int digits);
        longint max_val;
        int     w;
        max_val = 1;
        for (int i = 0; i < digits; i++) begin
            max_val = max_val * 10;
        end
        max_val = max_val - 1;
        w = 1;
        while ((longint'(1) << w) <= max_val) begin
            w++;
        end
        return w;
    endfunction

endpackage

// File: rtl/bcd_digit_adj.sv
// Single-digit corrector for reverse double-dabble: subtracts 3 from a digit that is 8 or more.
module bcd_digit_adj
    import bcd_pkg::*;
(
    input  logic [DIGIT_W-1:0] digit_i,
    output logic [DIGIT_W-1:0] digit_o
);

    assign digit_o = (digit_i >= ADJ_THRESH) ? (digit_i - ADJ_VAL) : digit_i;

endmodule

// File: rtl/bcd_to_bin.sv
// Sequential BCD-to-binary converter (reverse double-dabble, one step per clock).
// Optional build macro BCD_CHECK_EN adds a registered illegal-digit flag on bcd_err.
module bcd_to_bin
    import bcd_pkg::*;
#(
    parameter int DIGITS = 4,
    parameter int BIN_W  = 14
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [DIGIT_W*DIGITS-1:0] bcd_in,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [BIN_W-1:0]          bin_out,
    output logic                      bcd_err
);

    localparam int BCD_W  = DIGIT_W * DIGITS;
    localparam int WORK_W = BCD_W + BIN_W;
    localparam int CNT_W  = (BIN_W > 1) ? $clog2(BIN_W) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BIN_W - 1);

    state_t             state_q, state_d;
    logic [WORK_W-1:0]  work_q, work_d;
    logic [WORK_W-1:0]  work_shift;
    logic [WORK_W-1:0]  work_step;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               out_valid_q, out_valid_d;
    logic [BIN_W-1:0]   bin_out_q, bin_out_d;
    logic               load;

    assign load = (state_q == IDLE) && in_valid;

    // Work register is {bcd part, bin part}; the bcd LSB falls into the bin MSB on each shift.
    assign work_shift = work_q >> 1;
    assign work_step[BIN_W-1:0] = work_shift[BIN_W-1:0];

    generate
        for (genvar gi = 0; gi < DIGITS; gi++) begin : g_adj
            bcd_digit_adj u_adj (
                .digit_i (work_shift[BIN_W + DIGIT_W*gi +: DIGIT_W]),
                .digit_o (work_step [BIN_W + DIGIT_W*gi +: DIGIT_W])
            );
        end
    endgenerate

`ifdef BCD_CHECK_EN
    logic [DIGITS-1:0] digit_bad;
    logic              bcd_err_q, bcd_err_d;

    generate
        for (genvar gi = 0; gi < DIGITS; gi++) begin : g_chk
            assign digit_bad[gi] = (bcd_in[DIGIT_W*gi +: DIGIT_W] > DIGIT_MAX);
        end
    endgenerate

    assign bcd_err_d = load ? (|digit_bad) : bcd_err_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bcd_err_q <= 1'b0;
        end else begin
            bcd_err_q <= bcd_err_d;
        end
    end

    assign bcd_err = bcd_err_q;
`else
    assign bcd_err = 1'b0;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            work_q      <= '0;
            cnt_q       <= '0;
            out_valid_q <= 1'b0;
            bin_out_q   <= '0;
        end else begin
            state_q     <= state_d;
            work_q      <= work_d;
            cnt_q       <= cnt_d;
            out_valid_q <= out_valid_d;
            bin_out_q   <= bin_out_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        work_d      = work_q;
        cnt_d       = cnt_q;
        out_valid_d = out_valid_q;
        bin_out_d   = bin_out_q;

        case (state_q)
            IDLE: begin
                if (load) begin
                    work_d  = {bcd_in, {BIN_W{1'b0}}};
                    cnt_d   = '0;
                    state_d = CONV;
                end
            end
            CONV: begin
                work_d = work_step;
                cnt_d  = cnt_q + CNT_W'(1);
                if (cnt_q == CNT_LAST) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                // First DONE cycle captures the result; afterwards wait for the consumer.
                if (!out_valid_q) begin
                    out_valid_d = 1'b1;
                    bin_out_d   = work_q[BIN_W-1:0];
                end else if (out_ready) begin
                    out_valid_d = 1'b0;
                    state_d     = IDLE;
                end
            end
            default: begin
                state_d     = IDLE;
                out_valid_d = 1'b0;
            end
        endcase
    end

    assign in_ready  = (state_q == IDLE);
    assign out_valid = out_valid_q;
    assign bin_out   = bin_out_q;

endmodule

// File: tb/tb_bcd_to_bin.sv
// Self-checking bench for bcd_to_bin: vector table, directed handshake/reset sequences,
// and a randomised sweep with consumer stalls checked against a decimal-value model.
module tb_bcd_to_bin;

    localparam int DIGITS = 4;
    localparam int BIN_W  = 14;
    localparam int LAT    = BIN_W + 1;
    localparam int NRAND  = 40;
`ifdef BCD_CHECK_EN
    localparam int CHECK_ON = 1;
`else
    localparam int CHECK_ON = 0;
`endif

    logic                 clk = 1'b0;
    logic                 rst;
    logic                 in_valid;
    logic                 in_ready;
    logic [4*DIGITS-1:0]  bcd_in;
    logic                 out_valid;
    logic                 out_ready;
    logic [BIN_W-1:0]     bin_out;
    logic                 bcd_err;

    int n_checks = 0;
    int n_fail   = 0;
    int exp_q[$];

    typedef struct {
        logic [15:0] bcd;
        int          bin;
    } vec_t;

    vec_t vecs[9];

    always #5 clk = ~clk;

    bcd_to_bin #(.DIGITS(DIGITS), .BIN_W(BIN_W)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .bcd_in    (bcd_in),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .bin_out   (bin_out),
        .bcd_err   (bcd_err)
    );

    // Decimal value of a packed BCD word, digit 0 in the low nibble.
    function automatic int ref_value(input logic [15:0] bcd);
        int v;
        v = 0;
        for (int i = DIGITS - 1; i >= 0; i--) begin
            v = v * 10 + int'(bcd[4*i +: 4]);
        end
        return v;
    endfunction

    function automatic logic [15:0] to_bcd(input int value);
        logic [15:0] r;
        int          v;
        v = value;
        r = '0;
        for (int i = 0; i < DIGITS; i++) begin
            r[4*i +: 4] = 4'(v % 10);
            v = v / 10;
        end
        return r;
    endfunction

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic fail_now(input string name);
        n_checks++;
        n_fail++;
        $display("FAIL %s: bound expired", name);
    endtask

    // Presents one word and returns just after the accepting edge.
    task automatic send(input logic [15:0] bcd);
        int w;
        @(negedge clk);
        w = 0;
        while (!in_ready && w < 200) begin
            @(negedge clk);
            w++;
        end
        if (!in_ready) begin
            fail_now("send_timeout");
            return;
        end
        in_valid = 1'b1;
        bcd_in   = bcd;
        @(posedge clk);
        #1 in_valid = 1'b0;
    endtask

    // Returns the number of edges after acceptance until out_valid is seen (-1 on timeout).
    task automatic wait_out(output int lat);
        lat = -1;
        for (int k = 1; k <= 60; k++) begin
            @(negedge clk);
            if (out_valid) begin
                lat = k - 1;
                break;
            end
        end
        if (lat < 0) fail_now("out_valid_timeout");
    endtask

    initial begin
        int          lat;
        logic [15:0] b;
        bit          seen;

        vecs[0] = '{16'h1234, 1234};
        vecs[1] = '{16'h9999, 9999};
        vecs[2] = '{16'h0000, 0};
        vecs[3] = '{16'h0001, 1};
        vecs[4] = '{16'h0100, 100};
        vecs[5] = '{16'h5000, 5000};
        vecs[6] = '{16'h0009, 9};
        vecs[7] = '{16'h8000, 8000};
        vecs[8] = '{16'h0080, 80};

        rst       = 1'b1;
        in_valid  = 1'b0;
        bcd_in    = '0;
        out_ready = 1'b1;
        repeat (2) @(negedge clk);
        check("reset_in_ready",  int'(in_ready),  1);
        check("reset_out_valid", int'(out_valid), 0);
        check("reset_bin_out",   int'(bin_out),   0);
        check("reset_bcd_err",   int'(bcd_err),   0);
        @(posedge clk);
        #1 rst = 1'b0;

        // Vector table with the consumer always ready.
        for (int i = 0; i < 9; i++) begin
            send(vecs[i].bcd);
            wait_out(lat);
            check("vec_latency", lat, LAT);
            check("vec_bin", int'(bin_out), vecs[i].bin);
            check("vec_err", int'(bcd_err), 0);
            $display("vec %0d: bcd=%h bin=%0d lat=%0d", i, vecs[i].bcd, bin_out, lat);
            @(negedge clk);
            check("vec_valid_drop", int'(out_valid), 0);
            check("vec_ready_back", int'(in_ready), 1);
        end

        // Consumer stall while upstream already presents the next word.
        out_ready = 1'b0;
        send(16'h1234);
        wait_out(lat);
        check("stall_latency", lat, LAT);
        in_valid = 1'b1;
        bcd_in   = 16'h0042;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check("stall_valid", int'(out_valid), 1);
            check("stall_bin",   int'(bin_out),   1234);
            check("stall_ready", int'(in_ready),  0);
        end
        out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check("stall_release_ready", int'(in_ready), 1);
        check("stall_release_bin", int'(bin_out), 1234);
        @(posedge clk);
        #1 in_valid = 1'b0;
        wait_out(lat);
        check("stall_next_latency", lat, LAT);
        check("stall_next_bin", int'(bin_out), 42);
        $display("stall: held 1234 for 10 cycles, next result %0d", bin_out);
        @(negedge clk);

        // Reset in the middle of a conversion.
        send(16'h5678);
        repeat (7) @(posedge clk);
        #1 rst = 1'b1;
        #1;
        check("midrst_out_valid", int'(out_valid), 0);
        check("midrst_in_ready",  int'(in_ready),  1);
        check("midrst_bin_out",   int'(bin_out),   0);
        @(posedge clk);
        #1 rst = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 25; i++) begin
            @(negedge clk);
            if (out_valid) seen = 1'b1;
        end
        check("midrst_no_pulse", int'(seen), 0);
        check("midrst_ready_after", int'(in_ready), 1);
        send(16'h0001);
        wait_out(lat);
        check("midrst_next_latency", lat, LAT);
        check("midrst_next_bin", int'(bin_out), 1);
        $display("reset: 5678 abandoned, next result %0d", bin_out);
        @(negedge clk);

        // Illegal digit, then a clean word.
        send(16'h12A4);
        wait_out(lat);
        check("baddig_err", int'(bcd_err), CHECK_ON);
        $display("bad digit: bcd=12a4 err=%0d", bcd_err);
        @(negedge clk);
        send(16'h0100);
        wait_out(lat);
        check("gooddig_err", int'(bcd_err), 0);
        check("gooddig_bin", int'(bin_out), 100);
        $display("good digit: bcd=0100 err=%0d bin=%0d", bcd_err, bin_out);
        @(negedge clk);

        // Randomised sweep with consumer stalls and a scoreboard queue.
        fork
            begin
                for (int i = 0; i < NRAND; i++) begin
                    b = to_bcd($urandom_range(0, 9999));
                    send(b);
                    exp_q.push_back(ref_value(b));
                    repeat ($urandom_range(0, 3)) @(posedge clk);
                end
            end
            begin
                int got;
                int cyc;
                int e;
                got = 0;
                cyc = 0;
                while (got < NRAND && cyc < 6000) begin
                    @(negedge clk);
                    cyc++;
                    if (out_valid && out_ready) begin
                        if (exp_q.size() == 0) begin
                            fail_now("rand_unexpected_result");
                        end else begin
                            e = exp_q.pop_front();
                            check("rand_bin", int'(bin_out), e);
                            check("rand_err", int'(bcd_err), 0);
                            $display("rand %0d: bin=%0d expected=%0d", got, bin_out, e);
                        end
                        got++;
                    end
                    @(posedge clk);
                    #1 out_ready = ($urandom_range(0, 3) != 0);
                end
                if (got < NRAND) fail_now("rand_timeout");
                out_ready = 1'b1;
            end
        join
        repeat (30) @(negedge clk);
        check("rand_no_extra_valid", int'(out_valid), 0);
        check("rand_leftover", exp_q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
